// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: SLL/SRL/SRA, one log2 stage per register, valid/ready flow control.
// Define PIPELINED_SHIFTER_ROTATE_EN to build rotate-left for mode 11; otherwise mode 11 acts as SLL.
module pipelined_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int S = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [S-1:0]     in_shamt,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    // One fixed-distance shift; amt is a constant per stage so each stage is a simple mux.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input logic             sgn,
        input int               amt
    );
        logic [WIDTH-1:0] fill_mask;
        fill_mask = ~({WIDTH{1'b1}} >> amt);
        case (m)
            2'b01:   shift_step = d >> amt;
            2'b10:   shift_step = (d >> amt) | (sgn ? fill_mask : '0);
`ifdef PIPELINED_SHIFTER_ROTATE_EN
            2'b11:   shift_step = (d << amt) | (d >> (WIDTH - amt));
`endif
            default: shift_step = d << amt;
        endcase
    endfunction

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_stage
            logic             valid_reg;
            logic             sign_reg;
            logic [WIDTH-1:0] data_reg;
            logic [1:0]       mode_reg;
            logic [S-1:0]     shamt_reg;
            logic [TAG_W-1:0] tag_reg;

            logic             valid_prev;
            logic             sign_prev;
            logic [WIDTH-1:0] data_prev;
            logic [1:0]       mode_prev;
            logic [S-1:0]     shamt_prev;
            logic [TAG_W-1:0] tag_prev;
            logic [WIDTH-1:0] data_next;

            if (gi == 0) begin : g_src
                // The sign is captured once at acceptance and travels with the operand.
                assign valid_prev = in_valid;
                assign sign_prev  = in_data[WIDTH-1];
                assign data_prev  = in_data;
                assign mode_prev  = in_mode;
                assign shamt_prev = in_shamt;
                assign tag_prev   = in_tag;
            end else begin : g_src
                assign valid_prev = g_stage[gi-1].valid_reg;
                assign sign_prev  = g_stage[gi-1].sign_reg;
                assign data_prev  = g_stage[gi-1].data_reg;
                assign mode_prev  = g_stage[gi-1].mode_reg;
                assign shamt_prev = g_stage[gi-1].shamt_reg;
                assign tag_prev   = g_stage[gi-1].tag_reg;
            end

            assign data_next = shamt_prev[gi]
                             ? shift_step(data_prev, mode_prev, sign_prev, 1 << gi)
                             : data_prev;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    sign_reg  <= 1'b0;
                    data_reg  <= '0;
                    mode_reg  <= '0;
                    shamt_reg <= '0;
                    tag_reg   <= '0;
                end else if (adv) begin
                    valid_reg <= valid_prev;
                    sign_reg  <= sign_prev;
                    data_reg  <= data_next;
                    mode_reg  <= mode_prev;
                    shamt_reg <= shamt_prev;
                    tag_reg   <= tag_prev;
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[S-1].valid_reg;
    assign out_data  = g_stage[S-1].data_reg;
    assign out_tag   = g_stage[S-1].tag_reg;

endmodule
